queued_memory_controller: RTL and testbench

Parametrised host-to-memory bridge that supersedes the single-shot read controller: it accepts posted read and write requests from the host into a request FIFO, issues them one at a time on the memory bus with a ready handshake and timeout, and queues read data in a response FIFO. The host drains the response FIFO and reads status through register strobes. An interrupt flags available data or any sticky error. The block sits between the host bus and the memory device model.

---
 rtl/queued_memory_controller.sv | 227 ++++++++++++++++++++++
 tb/tb_queued_memory_controller.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/queued_memory_controller.sv
// Queued host-to-memory bridge.
// Host strobes post read/write requests into a request FIFO; a two-state
// memory FSM issues them one at a time with a ready/timeout handshake, and
// read data lands in a response FIFO drained through data-register reads.
// Memory handshake: the controller holds mem_cs plus one of mem_read or
// mem_write (with address/data) stable until mem_ready pulses for one cycle
// or the wait counter expires; each transaction is followed by at least one
// IDLE cycle with the strobes low.
module queued_memory_controller #(
   parameter int DW      = 16,
   parameter int AW      = 16,
   parameter int DEPTH   = 4,
   parameter int TIMEOUT = 15
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          cs,
   input  logic          read,
   input  logic          write,
   input  logic          sreg,
   input  logic          dreg,
   input  logic [AW-1:0] host_addr_bus,
   input  logic [DW-1:0] host_wdata,
   output logic [DW-1:0] host_data_bus,
   input  logic          mem_ready,
   input  logic [DW-1:0] mem_data_bus,
   output logic [AW-1:0] mem_addr_bus,
   output logic [DW-1:0] mem_wdata,
   output logic          mem_cs,
   output logic          mem_read,
   output logic          mem_write,
   output logic          intr,
   output logic          dbg_state_o
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam int TW = $clog2(TIMEOUT);
   localparam int EW = 1 + AW + DW;

   typedef enum logic {ST_IDLE, ST_BUSY} state_t;

   state_t          state_q, state_d;
   logic [TW-1:0]   tcnt_q, tcnt_d;
   logic            read_q, write_q;
   logic            mem_cs_q, mem_cs_d, mem_read_q, mem_read_d, mem_write_q, mem_write_d;
   logic [AW-1:0]   mem_addr_q, mem_addr_d;
   logic [DW-1:0]   mem_wdata_q, mem_wdata_d;
   logic [DW-1:0]   host_data_q, host_data_d;
   logic            ovf_q, ovf_d, to_q, to_d, cerr_q, cerr_d;

   logic [EW-1:0]   req_mem [DEPTH];
   logic [PW-1:0]   req_wptr_q, req_rptr_q;
   logic [CW-1:0]   req_cnt_q, req_cnt_d;
   logic [DW-1:0]   rsp_mem [DEPTH];
   logic [PW-1:0]   rsp_wptr_q, rsp_rptr_q;
   logic [CW-1:0]   rsp_cnt_q, rsp_cnt_d;

   // Host command decode (edge-detected strobes, level-held qualifiers)
   logic          rd_rise, wr_rise, rd_cmd, wr_cmd, no_qual;
   logic          req_push_req, req_push, req_pop, req_full, req_nonempty;
   logic          rsp_push, rsp_pop, rsp_empty, rsp_full;
   logic          sreg_rd, dreg_rd, ovf_set, to_set, cerr_set;
   logic [EW-1:0] req_head, req_entry;
   logic [DW-1:0] status;

   assign rd_rise      = read & ~read_q;
   assign wr_rise      = write & ~write_q;
   assign rd_cmd       = rd_rise & ~wr_rise;
   assign wr_cmd       = wr_rise & ~rd_rise;
   assign no_qual      = ~sreg & ~dreg;
   assign sreg_rd      = rd_cmd & sreg & ~dreg;
   assign dreg_rd      = rd_cmd & dreg & ~sreg;
   assign req_push_req = (rd_cmd | wr_cmd) & no_qual;
   assign req_full     = (req_cnt_q == CW'(DEPTH));
   assign req_nonempty = (req_cnt_q != '0);
   assign req_push     = req_push_req & ~req_full;
   assign ovf_set      = req_push_req & req_full;
   assign cerr_set     = (rd_rise & wr_rise) | (rd_cmd & sreg & dreg) | (wr_cmd & ~no_qual);
   assign rsp_empty    = (rsp_cnt_q == '0);
   assign rsp_full     = (rsp_cnt_q == CW'(DEPTH));
   assign rsp_pop      = dreg_rd & ~rsp_empty;
   assign req_entry    = {wr_cmd, host_addr_bus, wr_cmd ? host_wdata : {DW{1'b0}}};
   assign req_head     = req_mem[req_rptr_q];

   // Memory FSM next state and registered memory-bus outputs
   always_comb begin
      state_d     = state_q;
      tcnt_d      = tcnt_q;
      mem_cs_d    = mem_cs_q;
      mem_read_d  = mem_read_q;
      mem_write_d = mem_write_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      req_pop     = 1'b0;
      rsp_push    = 1'b0;
      to_set      = 1'b0;
      case (state_q)
         ST_IDLE: begin
            // A read is only issued when its response has somewhere to go
            if (req_nonempty && (req_head[EW-1] || !rsp_full)) begin
               state_d     = ST_BUSY;
               req_pop     = 1'b1;
               mem_addr_d  = req_head[AW+DW-1:DW];
               mem_wdata_d = req_head[DW-1:0];
               mem_cs_d    = 1'b1;
               mem_read_d  = ~req_head[EW-1];
               mem_write_d = req_head[EW-1];
               tcnt_d      = '0;
            end
         end
         ST_BUSY: begin
            if (mem_ready) begin
               state_d     = ST_IDLE;
               rsp_push    = mem_read_q & ~rsp_full;
               mem_cs_d    = 1'b0;
               mem_read_d  = 1'b0;
               mem_write_d = 1'b0;
            end else if (tcnt_q == TW'(TIMEOUT - 1)) begin
               state_d     = ST_IDLE;
               to_set      = 1'b1;
               mem_cs_d    = 1'b0;
               mem_read_d  = 1'b0;
               mem_write_d = 1'b0;
            end else begin
               tcnt_d = tcnt_q + TW'(1);
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Status word, register-read mux, sticky errors and FIFO occupancy
   always_comb begin
      status        = '0;
      status[0]     = ~rsp_empty;
      status[1]     = req_full;
      status[2]     = (state_q == ST_BUSY) | req_nonempty;
      status[3]     = ovf_q;
      status[4]     = to_q;
      status[5]     = cerr_q;
      status[8 +: CW] = rsp_cnt_q;

      host_data_d = host_data_q;
      if (sreg_rd)      host_data_d = status;
      else if (dreg_rd) host_data_d = rsp_empty ? '0 : rsp_mem[rsp_rptr_q];

      // A new error on the same edge as the acknowledge keeps the bit set
      ovf_d  = ovf_set  | (ovf_q  & ~cs);
      to_d   = to_set   | (to_q   & ~cs);
      cerr_d = cerr_set | (cerr_q & ~cs);

      req_cnt_d = req_cnt_q;
      case ({req_push, req_pop})
         2'b10:   req_cnt_d = req_cnt_q + CW'(1);
         2'b01:   req_cnt_d = req_cnt_q - CW'(1);
         default: req_cnt_d = req_cnt_q;
      endcase
      rsp_cnt_d = rsp_cnt_q;
      case ({rsp_push, rsp_pop})
         2'b10:   rsp_cnt_d = rsp_cnt_q + CW'(1);
         2'b01:   rsp_cnt_d = rsp_cnt_q - CW'(1);
         default: rsp_cnt_d = rsp_cnt_q;
      endcase
   end

   // Control and pointer registers with asynchronous reset
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         tcnt_q      <= '0;
         read_q      <= 1'b0;
         write_q     <= 1'b0;
         mem_cs_q    <= 1'b0;
         mem_read_q  <= 1'b0;
         mem_write_q <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         host_data_q <= '0;
         ovf_q       <= 1'b0;
         to_q        <= 1'b0;
         cerr_q      <= 1'b0;
         req_wptr_q  <= '0;
         req_rptr_q  <= '0;
         req_cnt_q   <= '0;
         rsp_wptr_q  <= '0;
         rsp_rptr_q  <= '0;
         rsp_cnt_q   <= '0;
      end else begin
         state_q     <= state_d;
         tcnt_q      <= tcnt_d;
         read_q      <= read;
         write_q     <= write;
         mem_cs_q    <= mem_cs_d;
         mem_read_q  <= mem_read_d;
         mem_write_q <= mem_write_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         host_data_q <= host_data_d;
         ovf_q       <= ovf_d;
         to_q        <= to_d;
         cerr_q      <= cerr_d;
         req_cnt_q   <= req_cnt_d;
         rsp_cnt_q   <= rsp_cnt_d;
         if (req_push) req_wptr_q <= req_wptr_q + PW'(1);
         if (req_pop)  req_rptr_q <= req_rptr_q + PW'(1);
         if (rsp_push) rsp_wptr_q <= rsp_wptr_q + PW'(1);
         if (rsp_pop)  rsp_rptr_q <= rsp_rptr_q + PW'(1);
      end
   end

   // FIFO storage; contents are meaningless outside the occupied window
   always_ff @(posedge clk) begin
      if (req_push) req_mem[req_wptr_q] <= req_entry;
      if (rsp_push) rsp_mem[rsp_wptr_q] <= mem_data_bus;
   end

   assign host_data_bus = host_data_q;
   assign mem_addr_bus  = mem_addr_q;
   assign mem_wdata     = mem_wdata_q;
   assign mem_cs        = mem_cs_q;
   assign mem_read      = mem_read_q;
   assign mem_write     = mem_write_q;
   assign intr          = ~rsp_empty | ovf_q | to_q | cerr_q;
   assign dbg_state_o   = (state_q == ST_BUSY);

endmodule

// File: tb/tb_queued_memory_controller.sv
// Scoreboard bench for queued_memory_controller: expected register reads and
// expected memory transactions are queued as stimulus is issued; monitors
// pop and compare when the DUT presents them.
module tb_queued_memory_controller;
  localparam int DW = 16;
  localparam int AW = 16;
  localparam int DEPTH = 4;
  localparam int TIMEOUT = 8;

  logic clk = 1'b0;
  logic rst, cs, read, write, sreg, dreg;
  logic [AW-1:0] host_addr_bus;
  logic [DW-1:0] host_wdata, host_data_bus;
  logic mem_ready;
  logic [DW-1:0] mem_data_bus, mem_wdata;
  logic [AW-1:0] mem_addr_bus;
  logic mem_cs, mem_read, mem_write, intr, dbg_state;

  int checks = 0;
  int failures = 0;
  int mem_delay = -1;
  int run_len = 0;
  int last_len = 0;
  logic [DW-1:0] exp_q[$];
  logic [AW+DW:0] exp_mem_q[$];

  // clock / reset block
  always #5 clk = ~clk;

  queued_memory_controller #(.DW(DW), .AW(AW), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .cs(cs), .read(read), .write(write), .sreg(sreg), .dreg(dreg),
    .host_addr_bus(host_addr_bus), .host_wdata(host_wdata), .host_data_bus(host_data_bus),
    .mem_ready(mem_ready), .mem_data_bus(mem_data_bus), .mem_addr_bus(mem_addr_bus),
    .mem_wdata(mem_wdata), .mem_cs(mem_cs), .mem_read(mem_read), .mem_write(mem_write),
    .intr(intr), .dbg_state_o(dbg_state)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // driver tasks (called at a falling edge, return at a falling edge)
  task automatic drive(input logic r, input logic w, input logic s, input logic d, input logic c,
                       input logic [AW-1:0] a, input logic [DW-1:0] wd);
    read = r; write = w; sreg = s; dreg = d; cs = c;
    host_addr_bus = a; host_wdata = wd;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
  endtask

  task automatic reg_read(input logic s, input logic d, input logic [DW-1:0] exp);
    exp_q.push_back(exp);
    drive(1'b1, 1'b0, s, d, 1'b0, '0, '0);
    idle(1);
  endtask

  task automatic post_read(input logic [AW-1:0] a);
    exp_mem_q.push_back({1'b0, a, {DW{1'b0}}});
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, a, '0);
    idle(1);
  endtask

  task automatic post_write(input logic [AW-1:0] a, input logic [DW-1:0] wd);
    exp_mem_q.push_back({1'b1, a, wd});
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, a, wd);
    idle(1);
  endtask

  task automatic cs_pulse();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, '0, '0);
  endtask

  // memory device model: answers each transaction after mem_delay cycles (-1 = never)
  initial begin : mem_model
    int d;
    logic [AW-1:0] a;
    mem_ready = 1'b0;
    mem_data_bus = '0;
    forever begin
      @(posedge mem_cs);
      #1;
      d = mem_delay;
      a = mem_addr_bus;
      if (d >= 0) begin
        repeat (d) @(posedge clk);
        @(negedge clk);
        mem_ready = 1'b1;
        mem_data_bus = (a == 16'h0042) ? 16'hBEEF : (16'hA500 | a);
        @(negedge clk);
        mem_ready = 1'b0;
        mem_data_bus = '0;
      end
    end
  end

  // scoreboard monitor for register reads
  initial begin : host_mon
    logic rh, wh, fire;
    rh = 1'b0;
    wh = 1'b0;
    forever begin
      @(posedge clk);
      if (rst) begin
        rh = 1'b0;
        wh = 1'b0;
      end else begin
        fire = read && !rh && !(write && !wh) && (sreg != dreg);
        rh = read;
        wh = write;
        if (fire) begin
          @(negedge clk);
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL host_reg unexpected update actual=0x%0h", host_data_bus);
          end else begin
            check("host_reg", host_data_bus, exp_q.pop_front());
          end
        end
      end
    end
  end

  // scoreboard monitor for memory transactions and strobe pulse length
  initial begin : mem_mon
    logic prev;
    logic [AW+DW:0] e;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (mem_cs && !prev) begin
        if (exp_mem_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL mem_issue unexpected addr actual=0x%0h", mem_addr_bus);
        end else begin
          e = exp_mem_q.pop_front();
          check("mem_write", mem_write, e[AW+DW]);
          check("mem_read", mem_read, !e[AW+DW]);
          check("mem_addr", mem_addr_bus, e[AW+DW-1:DW]);
          if (e[AW+DW]) check("mem_wdata", mem_wdata, e[DW-1:0]);
        end
      end
      prev = mem_cs;
      if (mem_read || mem_write) run_len++;
      else if (run_len > 0) begin
        last_len = run_len;
        run_len = 0;
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "simulation time limit");
  end

  initial begin : stim
    rst = 1'b1;
    read = 1'b0; write = 1'b0; sreg = 1'b0; dreg = 1'b0; cs = 1'b0;
    host_addr_bus = '0; host_wdata = '0;
    repeat (3) @(negedge clk);
    check("rst_host_data", host_data_bus, 16'h0000);
    check("rst_mem_cs", mem_cs, 1'b0);
    check("rst_mem_rd_wr", {mem_read, mem_write}, 2'b00);
    check("rst_mem_addr", mem_addr_bus, 16'h0000);
    check("rst_intr", intr, 1'b0);
    rst = 1'b0;
    idle(2);

    // single read of 0x0042, memory answers 0xBEEF
    mem_delay = 2;
    post_read(16'h0042);
    idle(1);
    check("t1_busy_read", mem_read, 1'b1);
    check("t1_intr_early", intr, 1'b0);
    idle(5);
    check("t1_read_len", last_len, 3);
    check("t1_intr", intr, 1'b1);
    reg_read(1'b1, 1'b0, 16'h0101);
    reg_read(1'b0, 1'b1, 16'hBEEF);
    check("t1_intr_after_pop", intr, 1'b0);

    // overflow: write stalls memory while four reads fill the queue, fifth dropped
    mem_delay = 7;
    exp_mem_q.push_back({1'b1, 16'h0030, 16'h5555});
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0030, 16'h5555);
    exp_mem_q.push_back({1'b0, 16'h0010, 16'h0000});
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0010, '0);
    idle(1);
    mem_delay = 1;
    for (int i = 1; i < 4; i++) begin
      exp_mem_q.push_back({1'b0, 16'h0010 + 16'(i), 16'h0000});
      drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0010 + 16'(i), '0);
      idle(1);
    end
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0014, '0);
    idle(1);
    check("t2_intr_ovf", intr, 1'b1);
    idle(20);
    reg_read(1'b1, 1'b0, 16'h0409);
    cs_pulse();
    reg_read(1'b1, 1'b0, 16'h0401);
    reg_read(1'b0, 1'b1, 16'hA510);
    reg_read(1'b0, 1'b1, 16'hA511);
    reg_read(1'b0, 1'b1, 16'hA512);
    check("t2_intr_nonempty", intr, 1'b1);
    reg_read(1'b0, 1'b1, 16'hA513);
    check("t2_intr_empty", intr, 1'b0);

    // write 0x1234 to 0x0020
    mem_delay = 1;
    post_write(16'h0020, 16'h1234);
    idle(6);
    check("t3_write_len", last_len, 2);
    check("t3_intr", intr, 1'b0);
    reg_read(1'b1, 1'b0, 16'h0000);

    // read timeout
    mem_delay = -1;
    post_read(16'h0060);
    idle(12);
    check("t4_timeout_len", last_len, 8);
    check("t4_intr", intr, 1'b1);
    reg_read(1'b1, 1'b0, 16'h0010);
    cs_pulse();
    reg_read(1'b1, 1'b0, 16'h0000);
    check("t4_intr_cleared", intr, 1'b0);

    // command errors and empty data read
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0070, 16'h7777);
    idle(4);
    check("t5_intr_cerr", intr, 1'b1);
    reg_read(1'b1, 1'b0, 16'h0020);
    reg_read(1'b0, 1'b1, 16'h0000);
    reg_read(1'b1, 1'b0, 16'h0020);
    cs_pulse();
    reg_read(1'b1, 1'b0, 16'h0000);
    drive(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, '0, '0);
    idle(1);
    reg_read(1'b1, 1'b0, 16'h0020);
    cs_pulse();
    check("t5_intr_cleared", intr, 1'b0);

    // reset while BUSY with two requests queued
    mem_delay = -1;
    post_read(16'h0050);
    post_read(16'h0051);
    post_read(16'h0052);
    check("t6_busy_before_rst", mem_cs, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    check("t6_rst_mem_cs", mem_cs, 1'b0);
    check("t6_rst_mem_read", mem_read, 1'b0);
    check("t6_rst_mem_addr", mem_addr_bus, 16'h0000);
    exp_mem_q.delete();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    idle(15);
    check("t6_no_activity", mem_cs, 1'b0);
    reg_read(1'b1, 1'b0, 16'h0000);
    check("t6_intr", intr, 1'b0);

    idle(2);
    check("mem_queue_drained", exp_mem_q.size(), 0);
    check("host_queue_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
